dtc_seq_eval: RTL and testbench

DTC_SEQ_EVAL -- requirements
Module: dtc_seq_eval

---
 rtl/dtc_seq_eval.sv | 149 ++++++++++++++
 tb/tb_dtc_seq_eval.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_seq_eval.sv
// Sequential decision-tree classifier: walks a register node table one node per clock
// from the root, steering on one feature bit per internal node, with a hop limit.
module dtc_seq_eval #(
  parameter int N_FEAT   = 9,
  parameter int CLS_W    = 1,
  parameter int ADDR_W   = 6,
  parameter int MAX_HOPS = 16,
  localparam int FIDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
  localparam int HOP_W   = $clog2(MAX_HOPS + 1),
  localparam int NODE_W  = 1 + CLS_W + FIDX_W + 2 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_FEAT-1:0] inp,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CLS_W-1:0]  outp,
  output logic              out_err,
  output logic [HOP_W-1:0]  out_hops,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [HOP_W-1:0]  MAX_HOPS_C = HOP_W'(MAX_HOPS);
  localparam logic [NODE_W-1:0] NODE_RST   = {1'b1, {(NODE_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic [N_FEAT-1:0] sample_q, sample_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [HOP_W-1:0]  hop_cnt_q, hop_cnt_d;
  logic [CLS_W-1:0]  outp_q, outp_d;
  logic              out_err_q, out_err_d;
  logic [HOP_W-1:0]  out_hops_q, out_hops_d;
  logic              tbl_we_d;

  logic [NODE_W-1:0] node_q [DEPTH];

  logic [NODE_W-1:0] nd;
  logic              nd_leaf;
  logic [CLS_W-1:0]  nd_cls;
  logic [FIDX_W-1:0] nd_fidx;
  logic [ADDR_W-1:0] nd_f, nd_t;
  logic              feat_bit;

  assign nd      = node_q[cur_addr_q];
  assign nd_leaf = nd[NODE_W-1];
  assign nd_cls  = nd[NODE_W-2 -: CLS_W];
  assign nd_fidx = nd[2*ADDR_W+FIDX_W-1 -: FIDX_W];
  assign nd_f    = nd[2*ADDR_W-1 -: ADDR_W];
  assign nd_t    = nd[ADDR_W-1:0];

  // Feature indices beyond the vector read as 0, so such nodes always take f_child.
  always_comb begin
    feat_bit = 1'b0;
    if (int'(nd_fidx) < N_FEAT) feat_bit = sample_q[nd_fidx];
  end

  // in_ready is held off until the first edge after reset release.
  assign in_ready  = rdy_en_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign outp      = outp_q;
  assign out_err   = out_err_q;
  assign out_hops  = out_hops_q;

  always_comb begin
    state_d    = state_q;
    rdy_en_d   = 1'b1;
    sample_d   = sample_q;
    cur_addr_d = cur_addr_q;
    hop_cnt_d  = hop_cnt_q;
    outp_d     = outp_q;
    out_err_d  = out_err_q;
    out_hops_d = out_hops_q;
    tbl_we_d   = cfg_we && (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sample_d   = inp;
          cur_addr_d = '0;
          hop_cnt_d  = '0;
          state_d    = S_WALK;
        end
      end
      S_WALK: begin
        if (nd_leaf) begin
          outp_d     = nd_cls;
          out_err_d  = 1'b0;
          out_hops_d = hop_cnt_q;
          state_d    = S_DONE;
        end else if (hop_cnt_q == MAX_HOPS_C) begin
          outp_d     = '0;
          out_err_d  = 1'b1;
          out_hops_d = MAX_HOPS_C;
          state_d    = S_DONE;
        end else begin
          cur_addr_d = feat_bit ? nd_t : nd_f;
          hop_cnt_d  = hop_cnt_q + HOP_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      cur_addr_q <= '0;
      hop_cnt_q  <= '0;
      outp_q     <= '0;
      out_err_q  <= 1'b0;
      out_hops_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= rdy_en_d;
      cur_addr_q <= cur_addr_d;
      hop_cnt_q  <= hop_cnt_d;
      outp_q     <= outp_d;
      out_err_q  <= out_err_d;
      out_hops_q <= out_hops_d;
    end
  end

  // The captured sample is pure data and needs no reset.
  always_ff @(posedge clk) begin
    sample_q <= sample_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) node_q[i] <= NODE_RST;
    end else if (tbl_we_d) begin
      node_q[cfg_addr] <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_dtc_seq_eval.sv
// Scoreboard bench for dtc_seq_eval: a driver pushes expected results from a
// table-walk reference model; a monitor pops and compares whenever out_valid rises.
module tb_dtc_seq_eval;

  localparam int N_FEAT   = 9;
  localparam int CLS_W    = 1;
  localparam int ADDR_W   = 6;
  localparam int MAX_HOPS = 16;
  localparam int FIDX_W   = 4;
  localparam int HOP_W    = 5;
  localparam int NODE_W   = 1 + CLS_W + FIDX_W + 2 * ADDR_W;
  localparam int DEPTH    = 64;

  logic              clk;
  logic              rst_n;
  logic [N_FEAT-1:0] inp;
  logic              in_valid;
  logic              in_ready;
  logic [CLS_W-1:0]  outp;
  logic              out_err;
  logic [HOP_W-1:0]  out_hops;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;

  dtc_seq_eval #(
    .N_FEAT(N_FEAT), .CLS_W(CLS_W), .ADDR_W(ADDR_W), .MAX_HOPS(MAX_HOPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
    .outp(outp), .out_err(out_err), .out_hops(out_hops), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int bp_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: node fields kept as plain integers.
  int m_leaf [DEPTH];
  int m_cls  [DEPTH];
  int m_fidx [DEPTH];
  int m_f    [DEPTH];
  int m_t    [DEPTH];

  typedef struct {
    int cls;
    int err;
    int hops;
    int acc;
  } exp_t;

  exp_t sbq [$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_leaf[i] = 1; m_cls[i] = 0; m_fidx[i] = 0; m_f[i] = 0; m_t[i] = 0;
    end
  endtask

  task automatic model_write(input int a, input int leaf, input int cls, input int fidx,
                             input int f, input int t);
    m_leaf[a] = leaf; m_cls[a] = cls; m_fidx[a] = fidx; m_f[a] = f; m_t[a] = t;
  endtask

  function automatic logic [NODE_W-1:0] enc(input int leaf, input int cls, input int fidx,
                                            input int f, input int t);
    return {leaf[0], cls[CLS_W-1:0], fidx[FIDX_W-1:0], f[ADDR_W-1:0], t[ADDR_W-1:0]};
  endfunction

  function automatic exp_t model_eval(input logic [N_FEAT-1:0] smp);
    exp_t e;
    int   a;
    a     = 0;
    e.acc = 0;
    for (int h = 0; h <= MAX_HOPS; h++) begin
      if (m_leaf[a] != 0) begin
        e.cls = m_cls[a]; e.err = 0; e.hops = h;
        return e;
      end
      if (h == MAX_HOPS) break;
      if (m_fidx[a] < N_FEAT && smp[m_fidx[a]] == 1'b1) a = m_t[a];
      else a = m_f[a];
    end
    e.cls = 0; e.err = 1; e.hops = MAX_HOPS;
    return e;
  endfunction

  // Monitor: compare each new result, then its stability while it is held.
  initial begin
    bit         seen;
    exp_t       e;
    logic [6:0] held;
    seen = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (!seen) begin
          seen = 1;
          held = {outp, out_err, out_hops};
          if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("outp", outp, e.cls);
            chk("out_err", out_err, e.err);
            chk("out_hops", out_hops, e.hops);
            chk("latency", cyc - e.acc, e.hops + 1);
          end
        end else begin
          chk("hold_stable", {outp, out_err, out_hops}, held);
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bp_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output bit ok);
    int n;
    n  = 0;
    ok = 1;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk("in_ready_timeout", 0, 1);
        ok = 0;
        return;
      end
    end
  endtask

  task automatic send(input logic [N_FEAT-1:0] smp, input bit with_cfg, input int ca,
                      input int leaf, input int cls, input int fidx, input int f, input int t);
    bit   ok;
    exp_t e;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    inp      = smp;
    in_valid = 1'b1;
    if (with_cfg) begin
      cfg_we    = 1'b1;
      cfg_addr  = ca[ADDR_W-1:0];
      cfg_wdata = enc(leaf, cls, fidx, f, t);
      model_write(ca, leaf, cls, fidx, f, t);
    end
    e = model_eval(smp);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    inp      = N_FEAT'($urandom);
  endtask

  task automatic send_simple(input logic [N_FEAT-1:0] smp);
    send(smp, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg_node(input int a, input int leaf, input int cls, input int fidx,
                          input int f, input int t);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a[ADDR_W-1:0];
    cfg_wdata = enc(leaf, cls, fidx, f, t);
    model_write(a, leaf, cls, fidx, f, t);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        chk("drain_timeout", sbq.size(), 0);
        sbq.delete();
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outp", outp, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_hops", out_hops, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);
  endtask

  initial begin
    logic [N_FEAT-1:0] smp;
    int n;
    rst_n     = 1'b0;
    inp       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    model_reset();

    do_reset();

    // Default table: root is a class-0 leaf.
    send_simple(N_FEAT'($urandom));
    drain();

    // Depth-3 tree.
    cfg_node(0, 0, 0, 1, 1, 2);
    cfg_node(1, 0, 0, 4, 3, 4);
    cfg_node(3, 1, 1, 0, 0, 0);
    cfg_node(4, 1, 0, 0, 0, 0);
    cfg_node(2, 1, 0, 0, 0, 0);
    smp = N_FEAT'($urandom); smp[1] = 1'b0; smp[4] = 1'b1;
    send_simple(smp);
    smp[4] = 1'b0;
    send_simple(smp);
    smp[1] = 1'b1;
    send_simple(smp);
    drain();

    // Loop trap hits the hop limit.
    cfg_node(0, 0, 0, 0, 0, 0);
    send_simple(N_FEAT'($urandom));
    drain();

    // Backpressure: hold the result, and a table write in DONE must be ignored.
    out_ready = 1'b0;
    send_simple(N_FEAT'($urandom));
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_wdata = enc(1, 1, 0, 0, 0);
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    drain();
    send_simple(N_FEAT'($urandom));
    drain();

    // Out-of-range feature index always follows f_child.
    cfg_node(0, 0, 0, 15, 1, 2);
    cfg_node(1, 1, 1, 0, 0, 0);
    cfg_node(2, 1, 0, 0, 0, 0);
    send_simple('1);
    send_simple('0);
    drain();
    cfg_node(0, 0, 0, 9, 1, 2);
    send_simple('1);
    drain();

    // Reset in the middle of a walk.
    cfg_node(0, 0, 0, 0, 0, 0);
    send_simple(N_FEAT'($urandom));
    repeat (4) @(negedge clk);
    do_reset();
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_valid", n, 0);
    send_simple(N_FEAT'($urandom));
    drain();

    // Random trees, random backpressure, occasional write alongside acceptance.
    bp_mode = 1;
    for (int a = 0; a < DEPTH; a++) begin
      cfg_node(a, int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)));
    end
    for (int k = 0; k < 40; k++) begin
      send(N_FEAT'($urandom), $urandom_range(0, 3) == 0, int'($urandom_range(0, 63)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 63)));
    end
    bp_mode   = 0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
